riscv_sc_core: RTL and testbench
================================

Name: riscv_sc_core

Overview:
- Single-cycle RV32I integer core; executes one instruction per CLK rising edge.
- Fetches from an external combinational-read instruction ROM through iaddr/idata.
- Accesses an external data RAM (synchronous write, combinational read) through daddr/ddata_r/ddata_w/d_rw.
- Top-level processing element of the single-cycle system; ROM and RAM are separate blocks.

Parameters:
- ADDR_WIDTH, 10, width of the word-index addresses driven to the ROM and RAM.
- SIZE, 32, datapath, register and memory word width; must be 32.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- idata  input  SIZE  instruction word read from the ROM at iaddr.
- iaddr  output  ADDR_WIDTH  instruction word index, equal to PC[ADDR_WIDTH+1:2].
- daddr  output  ADDR_WIDTH  data word index, equal to (rs1+imm)[ADDR_WIDTH+1:2].
- ddata_r  input  SIZE  data read from the RAM at daddr, combinational.
- ddata_w  output  SIZE  store data; always the rs2 value.
- d_rw  output  1  1 = RAM write this cycle, 0 = read.

Behaviour:
- State:
  - 32-bit PC.
  - 32x32 register file; x0 reads 0 and writes to it are discarded.
- Reset, asynchronous while RESET=1:
  - PC=0 and all registers cleared to 0.
  - iaddr=0, d_rw=0.
  - daddr, ddata_w follow combinationally from cleared state.
- Release: the first rising edge after RESET falls executes the instruction at PC 0.
- Each rising edge, with RESET=0:
  - PC <= next_pc.
  - rd <= result if the instruction writes a register.
  - The RAM captures the store on the same edge.
  - Latency: one cycle per instruction; no stalls, no pipeline.
- All outputs are combinational from the current PC, idata and register values.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- Immediates: I/S/B/U/J formats, sign-extended per RISC-V.
- Shifts use amount[4:0]; SRA/SRAI are arithmetic.
- SLT is signed, SLTU unsigned; both return 1 or 0.
- Arithmetic wraps modulo 2^32.
- next_pc:
  - PC+4 by default.
  - PC+imm for JAL and for taken branches.
  - (rs1+imm) with bit0 cleared for JALR.
  - JAL/JALR write PC+4 to rd; rd=x0 discards it.
- PC wraps at 2^32; iaddr takes bits [ADDR_WIDTH+1:2], so fetch wraps within the ROM. PC bits [1:0] are never used for fetch.
- Loads and stores:
  - Any load funct3 is treated as a word load: rd <= ddata_r.
  - Any store funct3 is treated as a word store: d_rw=1, ddata_w=rs2.
  - Byte offset bits [1:0] of the effective address are ignored.
- d_rw=1 only during a store with RESET=0.
- Unknown opcodes, FENCE and SYSTEM execute as NOP: PC+4, no register write, d_rw=0.
- Reset asserted mid-instruction: PC and registers clear immediately; no write occurs on that edge.

Optional Feature:
- Macro RV32M_MUL_EN.
- Defined: OP with funct7=0000001 and funct3=000 (MUL) writes the low 32 bits of rs1*rs2 to rd.
- Undefined: every OP instruction with funct7=0000001 is a NOP (PC+4, no register write).

Test Plan:
- Reset and fetch:
  - Hold RESET=1 for 2 cycles -> iaddr=0, d_rw=0.
  - Release with a ROM of NOPs -> iaddr steps 0,1,2,3 on successive edges.
- ALU and store:
  - Program: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SW x3,8(x0).
  - SW cycle -> d_rw=1, daddr=2, ddata_w=0x00000002.
- Load-use:
  - Program: preload RAM[2]=0xDEADBEEF; LW x4,8(x0); SW x4,12(x0).
  - SW cycle -> daddr=3, ddata_w=0xDEADBEEF.
  - The writes to x0 check: ADDI x0,x0,7; SW x0,0(x0) -> ddata_w=0.
- Branches:
  - x1=x2=5; BEQ x1,x2,+8 at PC 0x20 -> next iaddr=10.
  - BNE x1,x2,+8 at PC 0x20 -> next iaddr=9.
  - BLT -1 vs 1 taken; BLTU -1 vs 1 not taken.
- Jumps:
  - JAL x1,+16 at PC 0x10 -> next iaddr=8; a later SW x1 -> ddata_w=0x14.
  - JALR x0,0(x1) -> iaddr=5.
- Compare and shift:
  - SLT(-1,1)=1, SLTU(-1,1)=0.
  - SRAI of 0x80000000 by 4 -> 0xF8000000; SRLI -> 0x08000000.
  - LUI 0x12345 -> 0x12345000.
  - With RV32M_MUL_EN: MUL(7,-3) -> 0xFFFFFFEB.

Source files
------------

// File: rtl/riscv_sc_core.sv
// Single-cycle RV32I core: one instruction per rising CLK edge, combinational ROM/RAM ports.
// Optional RV32M_MUL_EN adds the MUL instruction; without it every funct7=0000001 OP is a NOP.
module riscv_sc_core #(
    parameter int ADDR_WIDTH = 10,
    parameter int SIZE       = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [SIZE-1:0]       idata,
    output logic [ADDR_WIDTH-1:0] iaddr,
    output logic [ADDR_WIDTH-1:0] daddr,
    input  logic [SIZE-1:0]       ddata_r,
    output logic [SIZE-1:0]       ddata_w,
    output logic                  d_rw
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    logic [SIZE-1:0] pc;
    logic [SIZE-1:0] next_pc;
    logic [SIZE-1:0] pc_plus4;
    logic [SIZE-1:0] regs [0:31];

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    logic [SIZE-1:0] rs1_val;
    logic [SIZE-1:0] rs2_val;
    logic [SIZE-1:0] imm_i;
    logic [SIZE-1:0] imm_s;
    logic [SIZE-1:0] imm_b;
    logic [SIZE-1:0] imm_u;
    logic [SIZE-1:0] imm_j;
    logic [SIZE-1:0] alu_b;
    logic [SIZE-1:0] alu_out;
    logic [SIZE-1:0] eff_addr;
    logic [SIZE-1:0] jalr_target;
    logic [SIZE-1:0] result;
    logic [4:0]      shamt;
    logic            alu_sub;
    logic            branch_taken;
    logic            reg_we;
    logic            is_store;
    logic            unused_addr_bits;

    assign opcode = idata[6:0];
    assign rd     = idata[11:7];
    assign funct3 = idata[14:12];
    assign rs1    = idata[19:15];
    assign rs2    = idata[24:20];
    assign funct7 = idata[31:25];

    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    assign imm_i = {{20{idata[31]}}, idata[31:20]};
    assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
    assign imm_b = {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};
    assign imm_u = {idata[31:12], 12'b0};
    assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};

    assign pc_plus4    = pc + 32'd4;
    assign jalr_target = (rs1_val + imm_i) & ~32'd1;
    assign eff_addr    = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

    assign iaddr   = pc[ADDR_WIDTH+1:2];
    assign daddr   = eff_addr[ADDR_WIDTH+1:2];
    assign ddata_w = rs2_val;
    assign d_rw    = is_store & ~RESET;

    // Byte offset and high address bits are deliberately dropped: all accesses are word-indexed.
    assign unused_addr_bits = ^{eff_addr[SIZE-1:ADDR_WIDTH+2], eff_addr[1:0]};

    // The ALU serves both OP and OP-IMM; bit 30 selects SUB (register form only) and SRA/SRAI.
    assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign alu_sub = (opcode == OPC_OP) && idata[30];
    assign shamt   = alu_b[4:0];

    always_comb begin
        alu_out = '0;
        case (funct3)
            3'b000: alu_out = alu_sub ? (rs1_val - alu_b) : (rs1_val + alu_b);
            3'b001: alu_out = rs1_val << shamt;
            3'b010: alu_out = {{(SIZE-1){1'b0}}, ($signed(rs1_val) < $signed(alu_b))};
            3'b011: alu_out = {{(SIZE-1){1'b0}}, (rs1_val < alu_b)};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = idata[30] ? $unsigned($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
            3'b110: alu_out = rs1_val | alu_b;
            3'b111: alu_out = rs1_val & alu_b;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = (rs1_val == rs2_val);
            3'b001: branch_taken = (rs1_val != rs2_val);
            3'b100: branch_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: branch_taken = (rs1_val < rs2_val);
            3'b111: branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

`ifdef RV32M_MUL_EN
    logic [SIZE-1:0] mul_lo;
    assign mul_lo = rs1_val * rs2_val;
`endif

    // Unlisted opcodes (FENCE, SYSTEM, garbage) fall through the defaults and act as NOPs.
    always_comb begin
        result   = '0;
        reg_we   = 1'b0;
        is_store = 1'b0;
        next_pc  = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                result = imm_u;
                reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                result = pc + imm_u;
                reg_we = 1'b1;
            end
            OPC_JAL: begin
                result  = pc_plus4;
                reg_we  = 1'b1;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                result  = pc_plus4;
                reg_we  = 1'b1;
                next_pc = jalr_target;
            end
            OPC_BRANCH: begin
                if (branch_taken) next_pc = pc + imm_b;
            end
            OPC_LOAD: begin
                result = ddata_r;
                reg_we = 1'b1;
            end
            OPC_STORE: begin
                is_store = 1'b1;
            end
            OPC_OP_IMM: begin
                result = alu_out;
                reg_we = 1'b1;
            end
            OPC_OP: begin
                if (funct7 == F7_MULDIV) begin
`ifdef RV32M_MUL_EN
                    if (funct3 == 3'b000) begin
                        result = mul_lo;
                        reg_we = 1'b1;
                    end
`endif
                end else begin
                    result = alu_out;
                    reg_we = 1'b1;
                end
            end
            default: begin
                result = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_we && (rd != 5'd0)) begin
            regs[rd] <= result;
        end
    end

endmodule

// File: tb/tb_riscv_sc_core.sv
// Directed-vector bench for riscv_sc_core: small programs in a modelled ROM, results observed
// through the store port. Expected MUL result depends on RV32M_MUL_EN.
module tb_riscv_sc_core;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] idata;
    logic [9:0]  iaddr;
    logic [9:0]  daddr;
    logic [31:0] ddata_r;
    logic [31:0] ddata_w;
    logic        d_rw;

    logic [31:0] rom [0:1023];
    logic [31:0] ram [0:1023];
    int checks = 0;
    int errors = 0;

    riscv_sc_core #(.ADDR_WIDTH(10), .SIZE(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .idata  (idata),
        .iaddr  (iaddr),
        .daddr  (daddr),
        .ddata_r(ddata_r),
        .ddata_w(ddata_w),
        .d_rw   (d_rw)
    );

    always #5 CLK = ~CLK;

    assign idata   = rom[iaddr];
    assign ddata_r = ram[daddr];

    always @(posedge CLK) begin
        if (d_rw) ram[daddr] <= ddata_w;
    end

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                          logic [31:0] rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3, logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_u(logic [31:0] imm20, logic [31:0] rd, logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic resetCore();
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            rom[i] = NOP;
            ram[i] = 32'h0;
        end
    endtask

    task automatic releaseCore();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic runTo(input int target, input string tag);
        int budget = 0;
        while ((32'(iaddr) != 32'(target)) && (budget < 64)) begin
            applyStimulus(1);
            budget++;
        end
        checkOutput(tag, 32'(iaddr), 32'(target));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset hold, then a ROM of NOPs must fetch sequentially.
        resetCore();
        repeat (2) @(negedge CLK);
        checkOutput("reset_iaddr", 32'(iaddr), 32'h0);
        checkOutput("reset_d_rw", 32'(d_rw), 32'h0);
        RESET = 1'b0;
        checkOutput("fetch_0", 32'(iaddr), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1);
            checkOutput("fetch_step", 32'(iaddr), 32'(i));
        end

        resetCore();
        rom[0] = enc_i(5, 0, 0, 1, OPC_OP_IMM);
        rom[1] = enc_i(32'hFFFF_FFFD, 0, 0, 2, OPC_OP_IMM);
        rom[2] = enc_r(0, 2, 1, 0, 3);
        rom[3] = enc_s(8, 3, 0);
        releaseCore();
        checkOutput("addi_d_rw", 32'(d_rw), 32'h0);
        runTo(3, "alu_runto");
        checkOutput("sw_d_rw", 32'(d_rw), 32'h1);
        checkOutput("sw_daddr", 32'(daddr), 32'h2);
        checkOutput("sw_data", ddata_w, 32'h0000_0002);
        applyStimulus(1);
        checkOutput("ram_word2", ram[2], 32'h0000_0002);
        checkOutput("nop_d_rw", 32'(d_rw), 32'h0);

        resetCore();
        ram[2] = 32'hDEAD_BEEF;
        rom[0] = enc_i(8, 0, 2, 4, OPC_LOAD);
        rom[1] = enc_s(12, 4, 0);
        rom[2] = enc_i(7, 0, 0, 0, OPC_OP_IMM);
        rom[3] = enc_s(0, 0, 0);
        releaseCore();
        checkOutput("lw_daddr", 32'(daddr), 32'h2);
        checkOutput("lw_d_rw", 32'(d_rw), 32'h0);
        applyStimulus(1);
        checkOutput("lu_daddr", 32'(daddr), 32'h3);
        checkOutput("lu_data", ddata_w, 32'hDEAD_BEEF);
        checkOutput("lu_d_rw", 32'(d_rw), 32'h1);
        runTo(3, "x0_runto");
        checkOutput("x0_data", ddata_w, 32'h0);
        checkOutput("x0_daddr", 32'(daddr), 32'h0);

        resetCore();
        rom[0]  = enc_i(5, 0, 0, 1, OPC_OP_IMM);
        rom[1]  = enc_i(5, 0, 0, 2, OPC_OP_IMM);
        rom[2]  = enc_i(32'hFFFF_FFFF, 0, 0, 5, OPC_OP_IMM);
        rom[3]  = enc_i(1, 0, 0, 6, OPC_OP_IMM);
        rom[8]  = enc_b(8, 2, 1, 0);
        rom[10] = enc_b(8, 2, 1, 1);
        rom[11] = enc_b(8, 6, 5, 4);
        rom[13] = enc_b(8, 6, 5, 6);
        rom[14] = enc_b(32'hFFFF_FFF8, 6, 5, 7);
        releaseCore();
        runTo(8, "br_runto");
        applyStimulus(1);
        checkOutput("beq_taken", 32'(iaddr), 32'd10);
        applyStimulus(1);
        checkOutput("bne_not_taken", 32'(iaddr), 32'd11);
        applyStimulus(1);
        checkOutput("blt_taken", 32'(iaddr), 32'd13);
        applyStimulus(1);
        checkOutput("bltu_not_taken", 32'(iaddr), 32'd14);
        applyStimulus(1);
        checkOutput("bgeu_backward", 32'(iaddr), 32'd12);

        resetCore();
        rom[4] = enc_j(16, 1);
        rom[5] = enc_i(7, 1, 0, 2, OPC_JALR);
        rom[6] = enc_j(4, 3);
        rom[7] = enc_s(0, 3, 0);
        rom[8] = enc_s(0, 1, 0);
        rom[9] = enc_i(0, 1, 0, 0, OPC_JALR);
        releaseCore();
        runTo(4, "jal_runto");
        applyStimulus(1);
        checkOutput("jal_target", 32'(iaddr), 32'd8);
        checkOutput("jal_link", ddata_w, 32'h0000_0014);
        applyStimulus(2);
        checkOutput("jalr_target", 32'(iaddr), 32'd5);
        applyStimulus(1);
        checkOutput("jalr_odd_target", 32'(iaddr), 32'd6);
        applyStimulus(1);
        checkOutput("jal_from_0x1a", 32'(iaddr), 32'd7);
        checkOutput("jalr_bit0_clear", ddata_w, 32'h0000_001E);

        resetCore();
        rom[0]  = enc_i(32'hFFFF_FFFF, 0, 0, 5, OPC_OP_IMM);
        rom[1]  = enc_i(1, 0, 0, 6, OPC_OP_IMM);
        rom[2]  = enc_r(0, 6, 5, 2, 7);
        rom[3]  = enc_s(0, 7, 0);
        rom[4]  = enc_r(0, 6, 5, 3, 7);
        rom[5]  = enc_s(0, 7, 0);
        rom[6]  = enc_u(32'h80000, 8, OPC_LUI);
        rom[7]  = enc_i(32'h404, 8, 5, 9, OPC_OP_IMM);
        rom[8]  = enc_s(0, 9, 0);
        rom[9]  = enc_i(32'h004, 8, 5, 9, OPC_OP_IMM);
        rom[10] = enc_s(0, 9, 0);
        rom[11] = enc_u(32'h12345, 10, OPC_LUI);
        rom[12] = enc_s(0, 10, 0);
        rom[13] = enc_r(32'h20, 5, 6, 0, 11);
        rom[14] = enc_s(0, 11, 0);
        rom[15] = enc_i(7, 0, 0, 13, OPC_OP_IMM);
        rom[16] = enc_i(32'hFFFF_FFFD, 0, 0, 14, OPC_OP_IMM);
        rom[17] = enc_r(32'h01, 14, 13, 0, 12);
        rom[18] = enc_s(0, 12, 0);
        rom[19] = enc_u(1, 15, OPC_AUIPC);
        rom[20] = enc_s(0, 15, 0);
        rom[21] = 32'hFFFF_FFFF;
        rom[22] = 32'h0000_0073;
        rom[23] = enc_s(0, 31, 0);
        releaseCore();
        runTo(3, "slt_runto");
        checkOutput("slt_signed", ddata_w, 32'h1);
        runTo(5, "sltu_runto");
        checkOutput("sltu_unsigned", ddata_w, 32'h0);
        runTo(8, "srai_runto");
        checkOutput("srai", ddata_w, 32'hF800_0000);
        runTo(10, "srli_runto");
        checkOutput("srli", ddata_w, 32'h0800_0000);
        runTo(12, "lui_runto");
        checkOutput("lui", ddata_w, 32'h1234_5000);
        runTo(14, "sub_runto");
        checkOutput("sub", ddata_w, 32'h0000_0002);
        runTo(18, "mul_runto");
`ifdef RV32M_MUL_EN
        checkOutput("mul", ddata_w, 32'hFFFF_FFEB);
`else
        checkOutput("mul_as_nop", ddata_w, 32'h0);
`endif
        runTo(20, "auipc_runto");
        checkOutput("auipc", ddata_w, 32'h0000_104C);
        runTo(21, "unknown_runto");
        checkOutput("unknown_d_rw", 32'(d_rw), 32'h0);
        applyStimulus(1);
        checkOutput("unknown_next", 32'(iaddr), 32'd22);
        applyStimulus(1);
        checkOutput("ecall_next", 32'(iaddr), 32'd23);
        checkOutput("unknown_no_write", ddata_w, 32'h0);

        // Reset arriving mid-store must suppress the write and clear state at once.
        resetCore();
        ram[1] = 32'h0000_0055;
        rom[0] = enc_i(9, 0, 0, 1, OPC_OP_IMM);
        rom[1] = enc_s(4, 1, 0);
        releaseCore();
        runTo(1, "midrst_runto");
        checkOutput("midrst_pre_data", ddata_w, 32'h0000_0009);
        checkOutput("midrst_pre_d_rw", 32'(d_rw), 32'h1);
        #1;
        RESET = 1'b1;
        rom[0] = enc_s(4, 1, 0);
        #1;
        checkOutput("midrst_d_rw", 32'(d_rw), 32'h0);
        checkOutput("midrst_iaddr", 32'(iaddr), 32'h0);
        checkOutput("midrst_regs_clear", ddata_w, 32'h0);
        applyStimulus(1);
        checkOutput("midrst_no_write", ram[1], 32'h0000_0055);
        RESET = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
